// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with single-cycle add/sub/compare/logic and iterative unsigned multiply/divide
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] lop,
    input  logic [WIDTH-1:0] rop,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [2*WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0]   opnd, opnd_d;
    logic [WIDTH-1:0]   result_d, hi_d, single_res;
    logic               zero_d, done_d;

    // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    // low bits of the wide subtraction are all the remainder needs
    assign div_diff = div_sh[WIDTH-1:0] - opnd;

    assign busy = (state != IDLE);

    always_comb begin
        single_res = '0;
        case (op)
            3'b000: single_res = lop + rop;
            3'b001: single_res = lop - rop;
            3'b010: single_res = {{(WIDTH-1){1'b0}}, (lop < rop)};
            3'b011: single_res = {{(WIDTH-1){1'b0}}, ($signed(lop) < $signed(rop))};
            3'b100: single_res = lop & rop;
            3'b101: single_res = lop | rop;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        acc_d    = acc;
        opnd_d   = opnd;
        result_d = result;
        hi_d     = hi;
        zero_d   = zero;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (op == 3'b110) begin
                        state_d = MUL;
                        acc_d   = {{WIDTH{1'b0}}, rop};
                        opnd_d  = lop;
                    end else if (op == 3'b111) begin
                        state_d = DIV;
                        acc_d   = {{WIDTH{1'b0}}, lop};
                        opnd_d  = rop;
                    end else begin
                        result_d = single_res;
                        hi_d     = '0;
                        zero_d   = (single_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc[WIDTH-1:1]};
                cnt_d = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_d  = IDLE;
                    result_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_d[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                end
            end
            DIV: begin
                // a zero divisor always "fits", giving all-ones quotient and the dividend as remainder
                acc_d = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
                cnt_d = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_d  = IDLE;
                    result_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_d[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            acc    <= acc_d;
            opnd   <= opnd_d;
            result <= result_d;
            hi     <= hi_d;
            zero   <= zero_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with a plain-arithmetic reference model
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] lop = '0;
    logic [W-1:0] rop = '0;
    logic [W-1:0] result, hi;
    logic         zero, busy, done;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .lop(lop), .rop(rop),
        .result(result), .hi(hi), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.hi = '0;
        e.res = '0;
        case (o)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = (a < b) ? W'(1) : W'(0);
            3'd3: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
            end
            default: begin
                if (b == '0) begin
                    e.res = '1;
                    e.hi  = a;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done cycle is one completion and must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            check("busy_low_at_done", 64'(busy), 64'(0));
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 expected no completion (result %h)", result);
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("hi", 64'(hi), 64'(e.hi));
                check("zero", 64'(zero), 64'(e.zero));
            end
        end
    end

    // drive at a negedge with busy low; returns just after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        lop   = a;
        rop   = b;
        sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        lop   = $urandom;
        rop   = $urandom;
        if (o >= 3'd6) check("busy_rise", 64'(busy), 64'(1));
        else           check("done_next_cycle", 64'(done), 64'(1));
    endtask

    task automatic wait_done(output int bc);
        bit seen;
        seen = 1'b0;
        bc = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic reset_check(input string tag);
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_hi"}, 64'(hi), 64'(0));
        check({tag, "_zero"}, 64'(zero), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int bc;
        logic [2:0] o;
        repeat (2) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;

        issue(3'd5, 32'h0000_F0F0, 32'h0000_0FF0);
        wait_done(bc);

        // abandon a multiply mid-flight
        issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("async_reset");
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done), 64'(0));

        issue(3'd0, 32'd3, 32'd4);
        check("add_3_4", 64'(result), 64'(7));
        wait_done(bc);

        issue(3'd1, 32'd5, 32'd5);                 wait_done(bc);
        issue(3'd2, 32'hFFFF_FFFF, 32'd1);         wait_done(bc);
        issue(3'd3, 32'hFFFF_FFFF, 32'd1);         wait_done(bc);
        issue(3'd0, 32'hFFFF_FFFF, 32'd1);         wait_done(bc);
        issue(3'd4, 32'h0000_F0F0, 32'h0000_0FF0); wait_done(bc);
        issue(3'd5, 32'h0000_F0F0, 32'h0000_0FF0); wait_done(bc);

        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc);
        check("mulu_busy_cycles", 64'(bc), 64'(W));
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'(0));

        issue(3'd7, 32'd100, 32'd7);
        wait_done(bc);
        check("divu_busy_cycles", 64'(bc), 64'(W));
        issue(3'd7, 32'd5, 32'd0);
        wait_done(bc);

        // start and operands wiggled while busy must not disturb the running divide
        issue(3'd7, 32'hDEAD_BEEF, 32'd1234);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            op    = 3'($urandom);
            lop   = $urandom;
            rop   = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);

        // next start issued during the done cycle
        check("b2b_in_done_cycle", 64'(done), 64'(1));
        issue(3'd6, 32'd6, 32'd7);
        wait_done(bc);

        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(o, pick(), pick());
            wait_done(bc);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU that adds iterative unsigned multiply and divide to the single-cycle add/sub/compare set. It is driven by the multicycle datapath controller through a start/busy/done handshake. The controller holds the pipeline while `busy` is high. It sits where the EX-stage ALU sits and produces a WIDTH-bit primary result, a WIDTH-bit `hi` word (product upper half or remainder) and a zero flag.

## Interface
- `WIDTH`, 32: operand and result width; must be at least 2.
- `CW`, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  opcode: 000 ADD, 001 SUB, 010 SLTU, 011 SLT (signed), 100 AND, 101 OR, 110 MULU, 111 DIVU.
- `lop`  in  WIDTH  left operand (multiplicand / dividend).
- `rop`  in  WIDTH  right operand (multiplier / divisor).
- `result`  out  WIDTH  registered primary result (sum, difference, compare, logic, product low half, quotient).
- `hi`  out  WIDTH  registered product high half or remainder; 0 for single-cycle ops.
- `zero`  out  1  registered; equals (`result`==0) for the operation last completed.
- `busy`  out  1  high while an iterative op is in progress.
- `done`  out  1  one-cycle pulse when `result`/`hi`/`zero` are updated.

## Operation
- States: IDLE, MUL, DIV.
- Start acceptance: `start`=1 with `busy`=0 at a rising edge. `start` is ignored while `busy`=1. A new start may be issued in the same cycle `done` is high.
- Operands and `op` are captured at the accepting edge. Later input changes have no effect on the operation in progress.
- Single-cycle ops (000–101): at the accepting edge, load `result`, `hi`=0 and `zero`, set `done`=1, and stay in IDLE.
  - ADD/SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
  - SLTU and SLT return 1 or 0 zero-extended to WIDTH.
- MULU: shift-add over an internal 2·WIDTH accumulator, one multiplier bit per cycle, for WIDTH iterations.
  - Final state: {`hi`,`result`} = `lop`·`rop`, unsigned.
- DIVU: restoring division, one quotient bit per cycle, for WIDTH iterations.
  - Final state: `result` = quotient, `hi` = remainder.
  - `rop`=0: `result` = all-ones and `hi` = `lop`, still after the full WIDTH iterations.
- Outputs hold their last values until the next completion. Intermediate iteration values never appear on `result`/`hi`/`zero`.
- `zero` is computed from the final `result` only; `hi` is ignored.

## Timing
- Reset, asynchronous and immediate on `rst_n`=0: state=IDLE, iteration counter=0, `result`=0, `hi`=0, `zero`=1, `busy`=0, `done`=0.
  - Any in-flight MUL/DIV is abandoned, with no `done`.
  - After `rst_n` deasserts, the first rising edge may accept a start.
- Single-cycle op accepted at edge k: `done`=1 and new outputs are visible after edge k; `done` drops after edge k+1 unless another op completes there.
- Iterative op accepted at edge k:
  - `busy`=1 after edge k.
  - Iterations run at edges k+1 … k+WIDTH.
  - At edge k+WIDTH: outputs are loaded, `busy`=0 and `done`=1.
  - Total latency is WIDTH cycles (32 for the default).
- `done` is never high for more than one cycle per completed operation. `busy` and `done` are never high together.
- Back-to-back: a start accepted at the completion edge's following cycle (when `done`=1) begins the next operation without an idle cycle.

## Test plan
- Reset defaults: assert `rst_n`=0 mid-MULU at iteration 10 → outputs return to the reset values immediately and no `done` follows; after release, ADD 3+4 → `result`=7 and `done`=1 one cycle after start.
- Single-cycle ops:
  - SUB 5−5 → `result`=0, `zero`=1.
  - SLTU 0xFFFFFFFF,1 → 0.
  - SLT 0xFFFFFFFF,1 → 1.
  - ADD 0xFFFFFFFF+1 → 0 with `zero`=1.
  - AND/OR 0xF0F0,0x0FF0 → 0x00F0 / 0xFFF0.
- MULU 0xFFFFFFFF×0xFFFFFFFF → `busy` high for 32 cycles; then `hi`=0xFFFFFFFE, `result`=0x00000001, `done` a single pulse.
- DIVU 100÷7 → `result`=14, `hi`=2 after 32 cycles. DIVU 5÷0 → `result`=0xFFFFFFFF, `hi`=5, `zero`=0.
- Handshake:
  - `start` toggled and operands changed while `busy` → ignored; the original result is delivered.
  - A start issued during the `done` cycle (MULU 6×7 → 42) → accepted, and `busy` rises on the next edge.
